// File: rtl/tweet_uart_rx_if.sv
// Signal bundle between the tweet board's serial receive stage and its consumers.
// The host side drives the line and the enable; the receiver returns characters and status.
interface tweet_uart_rx_if;
    logic       serial_in;
    logic       enable;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       break_det;
    logic       busy;

    modport master (
        output serial_in, enable,
        input  data_out, data_valid, frame_err, break_det, busy
    );

    modport slave (
        input  serial_in, enable,
        output data_out, data_valid, frame_err, break_det, busy
    );
endinterface

// File: rtl/tweet_uart_rx.sv
// 8N1 LSB-first serial receiver: synchronises the raw line, rejects false starts, samples
// mid-bit and reports good characters, framing errors and line breaks.
module tweet_uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HALF_BIT     = 2604,  // must be CLKS_PER_BIT/2
    parameter int CNT_W        = 13     // must hold CLKS_PER_BIT-1
) (
    input  logic          sysclk,
    input  logic          reset,
    tweet_uart_rx_if.slave rx
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BRK
    } state_t;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1;
    logic             rx_s;
    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             ferr_q;
    logic             brk_q;
    logic             busy_q;

    // NOTE: the synchroniser resets to the idle-high level so that leaving reset never
    // looks like a start edge.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx.serial_in;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle so each set below lasts exactly one cycle.
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rx.enable && !rx_s) begin
                        state  <= ST_START;
                        timer  <= '0;
                        busy_q <= 1'b1;
                    end
                end

                ST_START: begin
                    if (timer == HALF_LAST) begin
                        timer <= '0;
                        if (rx_s) begin
                            state  <= ST_IDLE;  // line bounced back high: false start
                            busy_q <= 1'b0;
                        end else begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (timer == BIT_LAST) begin
                        timer              <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end

                ST_STOP: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        if (rx_s) begin
                            data_q  <= shift_reg;
                            valid_q <= 1'b1;
                            state   <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else if (shift_reg != 8'h00) begin
                            ferr_q <= 1'b1;
                            state  <= ST_BRK;
                        end else begin
                            brk_q <= 1'b1;
                            state <= ST_BRK;
                        end
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end

                ST_BRK: begin
                    // Resync only after the line has been seen idle again.
                    if (rx_s) begin
                        brk_q  <= 1'b0;
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx.data_out   = data_q;
    assign rx.data_valid = valid_q;
    assign rx.frame_err  = ferr_q;
    assign rx.break_det  = brk_q;
    assign rx.busy       = busy_q;

endmodule

// File: tb/tb_tweet_uart_rx.sv
// Bench for tweet_uart_rx: directed scenarios plus random frames, checked every cycle
// against a sample-time model of the 8N1 receiver.
module tb_tweet_uart_rx;
    localparam int CPB   = 16;
    localparam int HALF  = 8;
    localparam int CNT_W = 5;

    logic sysclk = 1'b0;
    logic reset  = 1'b0;
    int   cyc    = 0;

    tweet_uart_rx_if bus();

    tweet_uart_rx #(
        .CLKS_PER_BIT(CPB),
        .HALF_BIT    (HALF),
        .CNT_W       (CNT_W)
    ) dut (
        .sysclk(sysclk),
        .reset (reset),
        .rx    (bus)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a frame detected at rx_s-low cycle s is sampled at s+HALF (start bit) and at
    // s+HALF+j*CPB for j=1..9 (data bits, then stop); results show the following cycle.
    typedef enum {M_IDLE, M_FRAME, M_BRK} mmode_t;
    mmode_t     m_mode = M_IDLE;
    int         m_s    = 0;
    logic [7:0] m_bits = 8'h00;
    logic       m_s1   = 1'b1;
    logic       m_s2   = 1'b1;
    logic [7:0] exp_data = 8'h00;
    logic       exp_dv = 1'b0, exp_fe = 1'b0, exp_brk = 1'b0, exp_busy = 1'b0;

    int         dv_count = 0, fe_count = 0;
    int         last_dv_cyc = -1, last_fe_cyc = -1, brk_rise_cyc = -1, brk_fall_cyc = -1;
    int         dv_cyc_q[$];
    logic [7:0] dv_dat_q[$];
    logic       prev_brk = 1'b0;

    task automatic model_step(input logic line, input logic en);
        logic r;
        int   k;
        r      = m_s2;
        exp_dv = 1'b0;
        exp_fe = 1'b0;
        case (m_mode)
            M_IDLE: if (en && !r) begin
                m_mode = M_FRAME;
                m_s    = cyc;
            end
            M_FRAME: begin
                k = cyc - m_s - HALF;
                if (k == 0) begin
                    if (r) m_mode = M_IDLE;
                end else if (k > 0 && (k % CPB) == 0) begin
                    if (k / CPB <= 8) begin
                        m_bits[k / CPB - 1] = r;
                    end else if (r) begin
                        exp_data = m_bits;
                        exp_dv   = 1'b1;
                        m_mode   = M_IDLE;
                    end else begin
                        if (m_bits != 8'h00) exp_fe = 1'b1;
                        else exp_brk = 1'b1;
                        m_mode = M_BRK;
                    end
                end
            end
            M_BRK: if (r) begin
                exp_brk = 1'b0;
                m_mode  = M_IDLE;
            end
            default: m_mode = M_IDLE;
        endcase
        exp_busy = (m_mode != M_IDLE);
        m_s2 = m_s1;
        m_s1 = line;
    endtask

    // Compare process: sample on the falling edge, well away from the active edge.
    initial begin
        forever begin
            @(negedge sysclk);
            if (!reset) begin
                m_s1 = 1'b1; m_s2 = 1'b1; m_mode = M_IDLE;
                exp_data = 8'h00; exp_dv = 1'b0; exp_fe = 1'b0; exp_brk = 1'b0; exp_busy = 1'b0;
            end
            check("data_out",   bus.data_out,   exp_data);
            check("data_valid", bus.data_valid, exp_dv);
            check("frame_err",  bus.frame_err,  exp_fe);
            check("break_det",  bus.break_det,  exp_brk);
            check("busy",       bus.busy,       exp_busy);
            check("dv_fe_excl", bus.data_valid & bus.frame_err, 1'b0);
            if (bus.data_valid) begin
                dv_count++;
                last_dv_cyc = cyc;
                dv_cyc_q.push_back(cyc);
                dv_dat_q.push_back(bus.data_out);
            end
            if (bus.frame_err) begin
                fe_count++;
                last_fe_cyc = cyc;
            end
            if (bus.break_det && !prev_brk) brk_rise_cyc = cyc;
            if (!bus.break_det && prev_brk) brk_fall_cyc = cyc;
            prev_brk = bus.break_det;
            if (reset) model_step(bus.serial_in, bus.enable);
        end
    end

    // Inputs change 1 time unit after the rising edge; each task leaves that phase intact.
    task automatic drive_bit(input logic v);
        bus.serial_in = v;
        repeat (CPB) @(posedge sysclk);
        #1;
    endtask

    task automatic line_high(input int n);
        bus.serial_in = 1'b1;
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, output int fall_cyc);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int fall, fall2, rel, dv0, fe0, kind, gap;
        logic [7:0] rb;

        bus.serial_in = 1'b1;
        bus.enable    = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        check("reset data_out",  bus.data_out,  8'h00);
        check("reset busy",      bus.busy,      1'b0);
        check("reset break_det", bus.break_det, 1'b0);
        reset      = 1'b1;
        bus.enable = 1'b1;
        line_high(10);

        // Good byte: 2 synchroniser cycles + HALF + 9*CPB + 1 = 155 cycles from the pin edge.
        dv0 = dv_count; fe0 = fe_count;
        send_frame(8'h41, 1'b1, fall);
        line_high(20);
        check("good latency", last_dv_cyc - fall, 155);
        check("good data",    bus.data_out,       8'h41);
        check("good pulses",  dv_count - dv0,     1);
        check("good no ferr", fe_count - fe0,     0);

        // Glitch shorter than half a bit.
        dv0 = dv_count;
        bus.serial_in = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        line_high(30);
        check("glitch pulses", dv_count - dv0, 0);
        check("glitch busy",   bus.busy,       1'b0);
        check("glitch data",   bus.data_out,   8'h41);

        // Framing error: non-zero data, stop bit low.
        dv0 = dv_count; fe0 = fe_count;
        send_frame(8'h55, 1'b0, fall);
        line_high(20);
        check("ferr pulses", fe_count - fe0,      1);
        check("ferr cycle",  last_fe_cyc - fall,  155);
        check("ferr no dv",  dv_count - dv0,      0);
        check("ferr data",   bus.data_out,        8'h41);
        check("ferr idle",   bus.busy,            1'b0);

        // Break: 20 bit times low, then release.
        dv0 = dv_count; fe0 = fe_count;
        fall = cyc;
        bus.serial_in = 1'b0;
        repeat (20 * CPB) @(posedge sysclk);
        #1;
        rel = cyc;
        line_high(20);
        check("break rise",  brk_rise_cyc - fall, 155);
        check("break fall",  brk_fall_cyc - rel,  3);
        check("break no dv", dv_count - dv0,      0);
        check("break no fe", fe_count - fe0,      0);

        // Back-to-back frames with no idle gap.
        dv_cyc_q.delete();
        dv_dat_q.delete();
        send_frame(8'h48, 1'b1, fall);
        send_frame(8'h69, 1'b1, fall2);
        line_high(20);
        check("b2b pulses", dv_cyc_q.size(), 2);
        if (dv_cyc_q.size() == 2) begin
            check("b2b spacing", dv_cyc_q[1] - dv_cyc_q[0], 10 * CPB);
            check("b2b first",   dv_dat_q[0], 8'h48);
            check("b2b second",  dv_dat_q[1], 8'h69);
        end

        // Reset in the middle of the data bits of 0x7F.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        repeat (5) @(posedge sysclk);
        #1;
        reset = 1'b0;
        bus.serial_in = 1'b1;
        #1;
        check("mid reset data", bus.data_out, 8'h00);
        check("mid reset busy", bus.busy,     1'b0);
        repeat (3) @(posedge sysclk);
        #1;
        reset = 1'b1;
        dv0 = dv_count;
        line_high(200);
        check("post reset no dv", dv_count - dv0, 0);

        // Enable gating.
        bus.enable = 1'b0;
        dv0 = dv_count;
        send_frame(8'h30, 1'b1, fall);
        line_high(20);
        check("disabled no dv", dv_count - dv0, 0);
        check("disabled busy",  bus.busy,       1'b0);
        bus.enable = 1'b1;
        line_high(5);
        send_frame(8'h31, 1'b1, fall);
        line_high(20);
        check("enabled data",  bus.data_out,   8'h31);
        check("enabled pulse", dv_count - dv0, 1);

        // Random traffic, checked cycle by cycle against the model.
        dv0 = dv_count;
        for (int it = 0; it < 40; it++) begin
            kind       = $urandom_range(0, 9);
            bus.enable = ($urandom_range(0, 7) != 0);
            rb         = 8'($urandom_range(0, 255));
            if (kind <= 6) begin
                gap = $urandom_range(0, 24);
                send_frame(rb, 1'b1, fall);
                line_high(gap);
            end else if (kind == 7) begin
                send_frame(rb, 1'b0, fall);
                line_high($urandom_range(0, 30));
            end else if (kind == 8) begin
                bus.serial_in = 1'b0;
                repeat ($urandom_range(1, 14)) @(posedge sysclk);
                #1;
                line_high($urandom_range(20, 40));
            end else begin
                bus.serial_in = 1'b0;
                repeat ($urandom_range(150, 250)) @(posedge sysclk);
                #1;
                line_high(30);
            end
        end
        bus.enable = 1'b1;
        line_high(300);
        check("random traffic received", (dv_count - dv0) > 0, 1'b1);
        check("random end idle",         bus.busy,              1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
